// File: rtl/iob_fifo_sync_ctrl.sv
// Single-clock FIFO controller that drives an external dual-port RAM (1-cycle registered read)
// as a circular buffer. It keeps the pointers, the occupancy level and the status flags.
module iob_fifo_sync_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic              w_en_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic              w_full_o,
    input  logic              r_en_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic              r_valid_o,
    output logic              r_empty_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              ext_mem_w_en_o,
    output logic [ADDR_W-1:0] ext_mem_w_addr_o,
    output logic [DATA_W-1:0] ext_mem_w_data_o,
    output logic              ext_mem_r_en_o,
    output logic [ADDR_W-1:0] ext_mem_r_addr_o,
    input  logic [DATA_W-1:0] ext_mem_r_data_i
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_level;
    logic              r_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_w_acc;
    logic              w_r_acc;

    // Flags come only from the level register, so the accept terms never depend
    // combinationally on the opposite side's request.
    always_comb begin
        w_full  = (r_level == LVL_FULL);
        w_empty = (r_level == '0);
        w_w_acc = w_en_i & ~w_full;
        w_r_acc = r_en_i & ~w_empty;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (rst_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_w_acc) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_r_acc) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            // A simultaneous accepted read and write leaves the occupancy unchanged.
            case ({w_w_acc, w_r_acc})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            r_valid     <= w_r_acc;
            r_overflow  <= w_en_i & w_full;
            r_underflow <= r_en_i & w_empty;
        end
    end

    assign ext_mem_w_en_o   = w_w_acc;
    assign ext_mem_w_addr_o = r_wptr;
    assign ext_mem_w_data_o = w_data_i;
    assign ext_mem_r_en_o   = w_r_acc;
    assign ext_mem_r_addr_o = r_rptr;

    assign r_data_o    = ext_mem_r_data_i;
    assign r_valid_o   = r_valid;
    assign w_full_o    = w_full;
    assign r_empty_o   = w_empty;
    assign level_o     = r_level;
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

endmodule

// File: tb/tb_iob_fifo_sync_ctrl.sv
// Directed bench for iob_fifo_sync_ctrl (depth 4) with a behavioural dual-port RAM
// attached to its memory ports; expected values are hand-computed constants.
module tb_iob_fifo_sync_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              arst_n;
    logic              rst;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_full;
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [DATA_W-1:0] mem_w_data;
    logic              mem_r_en;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [DATA_W-1:0] mem_r_data;

    logic [DATA_W-1:0] mem [4];

    int n_cmp = 0;
    int n_bad = 0;

    iob_fifo_sync_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i            (clk),
        .arst_n_i         (arst_n),
        .rst_i            (rst),
        .w_en_i           (w_en),
        .w_data_i         (w_data),
        .w_full_o         (w_full),
        .r_en_i           (r_en),
        .r_data_o         (r_data),
        .r_valid_o        (r_valid),
        .r_empty_o        (r_empty),
        .level_o          (level),
        .overflow_o       (overflow),
        .underflow_o      (underflow),
        .ext_mem_w_en_o   (mem_w_en),
        .ext_mem_w_addr_o (mem_w_addr),
        .ext_mem_w_data_o (mem_w_data),
        .ext_mem_r_en_o   (mem_r_en),
        .ext_mem_r_addr_o (mem_r_addr),
        .ext_mem_r_data_i (mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= mem[mem_r_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n = 1'b0;
        rst    = 1'b0;
        w_en   = 1'b0;
        w_data = '0;
        r_en   = 1'b0;
        #2;
        check("rst_empty", 32'(r_empty), 32'd1);
        check("rst_full", 32'(w_full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(r_valid), 32'd0);
        #10 arst_n = 1'b1;

        // Idle after reset: no RAM traffic.
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("idle_wen", 32'(mem_w_en), 32'd0);
            check("idle_ren", 32'(mem_r_en), 32'd0);
            check("idle_empty", 32'(r_empty), 32'd1);
        end

        // Fill with A0..A3.
        for (int i = 0; i < 4; i++) begin
            w_en   = 1'b1;
            w_data = 8'hA0 + 8'(i);
            #1;
            check("wr_en", 32'(mem_w_en), 32'd1);
            check("wr_addr", 32'(mem_w_addr), 32'(i));
            check("wr_data", 32'(mem_w_data), 32'hA0 + 32'(i));
            cyc();
            check("wr_level", 32'(level), 32'(i + 1));
            check("wr_empty", 32'(r_empty), 32'd0);
            check("wr_full", 32'(w_full), (i == 3) ? 32'd1 : 32'd0);
        end

        // Write into a full FIFO.
        w_data = 8'hFF;
        #1;
        check("ovf_wen", 32'(mem_w_en), 32'd0);
        cyc();
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd4);
        w_en = 1'b0;
        cyc();
        check("ovf_clear", 32'(overflow), 32'd0);

        // Drain A0..A3.
        for (int i = 0; i < 4; i++) begin
            r_en = 1'b1;
            #1;
            check("rd_en", 32'(mem_r_en), 32'd1);
            check("rd_addr", 32'(mem_r_addr), 32'(i));
            cyc();
            check("rd_valid", 32'(r_valid), 32'd1);
            check("rd_data", 32'(r_data), 32'hA0 + 32'(i));
            check("rd_level", 32'(level), 32'(3 - i));
        end
        check("rd_empty", 32'(r_empty), 32'd1);

        // Read from an empty FIFO.
        #1;
        check("udf_ren", 32'(mem_r_en), 32'd0);
        cyc();
        check("udf_pulse", 32'(underflow), 32'd1);
        check("udf_valid", 32'(r_valid), 32'd0);
        r_en = 1'b0;
        cyc();
        check("udf_clear", 32'(underflow), 32'd0);

        // Wrap-around: prefill 0x10,0x11 then four write/read pairs and a drain of two.
        for (int i = 0; i < 2; i++) begin
            w_en   = 1'b1;
            w_data = 8'h10 + 8'(i);
            cyc();
        end
        for (int k = 0; k < 4; k++) begin
            w_en   = 1'b1;
            r_en   = 1'b1;
            w_data = 8'h12 + 8'(k);
            #1;
            check("wrap_waddr", 32'(mem_w_addr), 32'((k + 2) % 4));
            check("wrap_raddr", 32'(mem_r_addr), 32'(k % 4));
            cyc();
            check("wrap_level", 32'(level), 32'd2);
            check("wrap_data", 32'(r_data), 32'h10 + 32'(k));
        end
        w_en = 1'b0;
        for (int k = 4; k < 6; k++) begin
            cyc();
            check("wrap_drain", 32'(r_data), 32'h10 + 32'(k));
        end
        r_en = 1'b0;
        cyc();
        check("wrap_empty", 32'(r_empty), 32'd1);

        // Simultaneous requests when full.
        for (int i = 0; i < 4; i++) begin
            w_en   = 1'b1;
            w_data = 8'h20 + 8'(i);
            cyc();
        end
        r_en   = 1'b1;
        w_data = 8'hEE;
        #1;
        check("fboth_wen", 32'(mem_w_en), 32'd0);
        check("fboth_ren", 32'(mem_r_en), 32'd1);
        cyc();
        check("fboth_level", 32'(level), 32'd3);
        check("fboth_ovf", 32'(overflow), 32'd1);
        check("fboth_data", 32'(r_data), 32'h20);
        w_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            cyc();
            check("fboth_drain", 32'(r_data), 32'h20 + 32'(i));
        end

        // Simultaneous requests when empty.
        w_en   = 1'b1;
        w_data = 8'h33;
        #1;
        check("eboth_wen", 32'(mem_w_en), 32'd1);
        check("eboth_ren", 32'(mem_r_en), 32'd0);
        cyc();
        check("eboth_level", 32'(level), 32'd1);
        check("eboth_udf", 32'(underflow), 32'd1);
        check("eboth_valid", 32'(r_valid), 32'd0);
        r_en = 1'b0;

        // Asynchronous reset with level 3 and a read result pending.
        for (int i = 0; i < 3; i++) begin
            w_data = 8'h34 + 8'(i);
            cyc();
        end
        w_en = 1'b0;
        r_en = 1'b1;
        cyc();
        r_en = 1'b0;
        check("pre_arst_level", 32'(level), 32'd3);
        check("pre_arst_valid", 32'(r_valid), 32'd1);
        check("pre_arst_data", 32'(r_data), 32'h33);
        arst_n = 1'b0;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_valid", 32'(r_valid), 32'd0);
        check("arst_empty", 32'(r_empty), 32'd1);
        check("arst_full", 32'(w_full), 32'd0);
        #5 arst_n = 1'b1;
        cyc();
        w_en   = 1'b1;
        w_data = 8'h77;
        #1;
        check("post_arst_wen", 32'(mem_w_en), 32'd1);
        check("post_arst_waddr", 32'(mem_w_addr), 32'd0);
        cyc();
        w_en = 1'b0;
        check("post_arst_level", 32'(level), 32'd1);

        // Synchronous clear.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("srst_level", 32'(level), 32'd0);
        check("srst_empty", 32'(r_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
